seq_divider: RTL and testbench
==============================

SEQ_DIVIDER -- requirements
Module: seq_divider

Interface
REQ-001 Parameter: N, default 8, divisor/remainder width; dividend/quotient width is 2N.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 rst  input  1  reset, synchronous, active-high.
REQ-004 start  input  1  request; sampled only in IDLE.
REQ-005 dividend  input  2N  unsigned numerator; captured on an accepted start.
REQ-006 divisor  input  N  unsigned denominator; captured on an accepted start.
REQ-007 busy  output  1  high while an operation is in progress.
REQ-008 done  output  1  one-cycle pulse; quotient/remainder are valid.
REQ-009 quotient  output  2N  registered result.
REQ-010 remainder  output  N  registered result.
REQ-011 dz  output  1  divide-by-zero flag; valid with done.

Function
REQ-012 Unsigned restoring shift-subtract division SHALL be used, one quotient bit per cycle, MSB first.
REQ-013 FSM states SHALL be IDLE, RUN and DONE; no other reachable states.
REQ-014 IDLE with start=1 SHALL capture dividend/divisor, clear partial remainder (N+1 bits) and bit counter, set busy=1, and go to RUN.
REQ-015 IDLE with start=0 SHALL hold all outputs unchanged.
REQ-016 Each RUN cycle SHALL shift {partial[N-1:0], next dividend bit} into the partial remainder; if partial >= divisor, it SHALL subtract the divisor and emit quotient bit 1, else emit 0.
REQ-017 RUN SHALL last exactly 2N cycles (16 for N=8), then go to DONE.
REQ-018 On entering DONE, quotient and remainder SHALL be updated; done=1 and busy=0 for exactly one cycle, then return to IDLE.
REQ-019 Latency SHALL be: start sampled at edge k gives done high in the cycle after edge k+2N+1 (edge 17 for N=8).
REQ-020 quotient/remainder SHALL hold their values from DONE until the next DONE or rst.
REQ-021 start SHALL be ignored in RUN and DONE; captured operands SHALL NOT change mid-operation.
REQ-022 Back-to-back: start held high SHALL be accepted in the IDLE cycle following DONE.
REQ-023 Results SHALL satisfy dividend = quotient*divisor + remainder, with remainder < divisor, for every divisor != 0.

Reset
REQ-024 rst=1 at a clock edge SHALL force IDLE with busy=0, done=0, dz=0, quotient=0, remainder=0, counter=0 and partial=0.
REQ-025 rst SHALL take priority over start and abort any RUN/DONE in progress; no done pulse SHALL follow an aborted operation.

Configuration
REQ-026 Macro SEQ_DIVIDER_DZ_EN SHALL control divide-by-zero detection.
REQ-027 With SEQ_DIVIDER_DZ_EN defined: an accepted start with divisor=0 SHALL go IDLE->DONE directly, with done one cycle after the start edge, dz=1, quotient all-ones, remainder=dividend[N-1:0]; dz=0 for all other results.
REQ-028 Without SEQ_DIVIDER_DZ_EN: dz SHALL be tied 0; divisor=0 SHALL run the full 2N cycles and produce the algorithmic result (quotient all-ones, remainder=dividend[N-1:0]).

Verification
REQ-029 dividend=0x03E8, divisor=0x07, start 1 cycle -> done 17 cycles later, quotient=0x008E, remainder=0x06, dz=0.
REQ-030 dividend=0xFFFF, divisor=0xFF -> quotient=0x0101, remainder=0x00; dividend=0x0005, divisor=0x09 -> quotient=0x0000, remainder=0x05.
REQ-031 divisor=0, dividend=0x1234 -> with macro: done after 1 cycle, dz=1, quotient=0xFFFF, remainder=0x34; without macro: done after 17 cycles, dz=0, same values.
REQ-032 start pulsed again at RUN cycle 5 with different operands -> ignored; first result unchanged, exactly one done pulse.
REQ-033 rst asserted at RUN cycle 8 -> next cycle busy=0, quotient=0, remainder=0; no done pulse for 20 cycles without start.
REQ-034 start held high for 40 cycles with 0x0064/0x0A -> two done pulses 18 cycles apart, each with quotient=0x000A, remainder=0x00.

Source files
------------

// File: rtl/seq_divider.sv
// ---------------------------------------------------------------------------
// seq_divider
//   Unsigned sequential divider using restoring shift-subtract division.
//   It produces one quotient bit per clock, MSB first. A 2N-bit dividend
//   is divided by an N-bit divisor, giving a 2N-bit quotient and an N-bit
//   remainder.
//
//   Optional feature (compile-time macro SEQ_DIVIDER_DZ_EN):
//     When defined, a zero divisor skips the iteration and completes at once
//     with dz=1.
//     When undefined, dz is tied low and a zero divisor runs the normal
//     algorithm. That gives an all-ones quotient and dividend[N-1:0] as the
//     remainder.
//
// Ports
//   clk        in   1    rising-edge clock
//   rst        in   1    synchronous, active-high reset
//   start      in   1    operation request, only looked at while idle
//   dividend   in   2N   unsigned numerator, captured when start is accepted
//   divisor    in   N    unsigned denominator, captured when start is accepted
//   busy       out  1    operation in progress
//   done       out  1    one-cycle pulse, results valid
//   quotient   out  2N   registered quotient, held until the next result
//   remainder  out  N    registered remainder, held until the next result
//   dz         out  1    divide-by-zero flag, valid with done
// ---------------------------------------------------------------------------
module seq_divider #(
  parameter int N = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2*N-1:0]   dividend,
  input  logic [N-1:0]     divisor,
  output logic             busy,
  output logic             done,
  output logic [2*N-1:0]   quotient,
  output logic [N-1:0]     remainder,
  output logic             dz
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int CW = $clog2(2 * N);
  localparam logic [CW-1:0] LAST_BIT = CW'(2 * N - 1);

  state_t           state_q, state_d;
  logic [2*N-1:0]   dividend_q, dividend_d;
  logic [N-1:0]     divisor_q, divisor_d;
  logic [N-1:0]     partial_q, partial_d;
  logic [2*N-1:0]   quot_work_q, quot_work_d;
  logic [CW-1:0]    count_q, count_d;
  logic [2*N-1:0]   quotient_q, quotient_d;
  logic [N-1:0]     remainder_q, remainder_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Trial partial remainder for this iteration. It is N+1 bits wide.
  // After a subtract the partial remainder is always below the divisor, so
  // only N bits need storing between cycles.
  logic [N:0]       trial;
  logic [N-1:0]     trial_diff;
  logic             q_bit;

`ifdef SEQ_DIVIDER_DZ_EN
  logic             dz_q, dz_d;
`endif

  // Next-state and datapath logic.
  // The state register sequences IDLE -> RUN (2N iterations) -> DONE -> IDLE.
  // done and busy are registered, so the done pulse appears in the cycle
  // after the FSM leaves DONE. busy falls on that same edge.
  always_comb begin
    state_d     = state_q;
    dividend_d  = dividend_q;
    divisor_d   = divisor_q;
    partial_d   = partial_q;
    quot_work_d = quot_work_q;
    count_d     = count_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;
    done_d      = 1'b0;
`ifdef SEQ_DIVIDER_DZ_EN
    dz_d        = dz_q;
`endif

    trial      = {partial_q, dividend_q[2*N-1]};
    q_bit      = (trial >= {1'b0, divisor_q});
    // Whenever q_bit is set the true difference fits in N bits,
    // so a modulo-2^N subtract is exact.
    trial_diff = trial[N-1:0] - divisor_q;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          dividend_d  = dividend;
          divisor_d   = divisor;
          partial_d   = '0;
          quot_work_d = '0;
          count_d     = '0;
          state_d     = RUN;
`ifdef SEQ_DIVIDER_DZ_EN
          if (divisor == '0) begin
            state_d     = DONE;
            quotient_d  = '1;
            remainder_d = dividend[N-1:0];
            dz_d        = 1'b1;
          end
`endif
        end
      end

      RUN: begin
        partial_d   = q_bit ? trial_diff : trial[N-1:0];
        dividend_d  = {dividend_q[2*N-2:0], 1'b0};
        quot_work_d = {quot_work_q[2*N-2:0], q_bit};
        count_d     = count_q + 1'b1;
        if (count_q == LAST_BIT) begin
          state_d     = DONE;
          quotient_d  = {quot_work_q[2*N-2:0], q_bit};
          remainder_d = q_bit ? trial_diff : trial[N-1:0];
`ifdef SEQ_DIVIDER_DZ_EN
          dz_d        = 1'b0;
`endif
        end
      end

      DONE: begin
        state_d = IDLE;
        done_d  = 1'b1;
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and datapath registers. A synchronous reset clears everything,
  // which also abandons any operation in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      dividend_q  <= '0;
      divisor_q   <= '0;
      partial_q   <= '0;
      quot_work_q <= '0;
      count_q     <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
`ifdef SEQ_DIVIDER_DZ_EN
      dz_q        <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      dividend_q  <= dividend_d;
      divisor_q   <= divisor_d;
      partial_q   <= partial_d;
      quot_work_q <= quot_work_d;
      count_q     <= count_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
`ifdef SEQ_DIVIDER_DZ_EN
      dz_q        <= dz_d;
`endif
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign quotient  = quotient_q;
  assign remainder = remainder_q;
`ifdef SEQ_DIVIDER_DZ_EN
  assign dz        = dz_q;
`else
  assign dz        = 1'b0;
`endif

endmodule

// File: tb/tb_seq_divider.sv
// ---------------------------------------------------------------------------
// tb_seq_divider
//   Self-checking bench for seq_divider (N=8). Expected results come from
//   plain integer division. The divide-by-zero behaviour follows the same
//   SEQ_DIVIDER_DZ_EN macro that the design is compiled with.
// ---------------------------------------------------------------------------
module tb_seq_divider;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] dividend;
  logic [7:0]  divisor;
  logic        busy;
  logic        done;
  logic [15:0] quotient;
  logic [7:0]  remainder;
  logic        dz;

  int total;
  int bad;
  int done_pulses;

`ifdef SEQ_DIVIDER_DZ_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  seq_divider #(.N(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .dz        (dz)
  );

  // 100 MHz clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count done pulses independently of any single test, sampled mid-cycle
  always @(negedge clk) begin
    if (done) done_pulses++;
  end

  // Hard time limit so a stuck design can never hang the run
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Compare one observed value against its expected value and record it
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  // Reference behaviour: integer division; zero divisor gives all-ones
  // quotient and the low dividend byte as remainder
  task automatic modelDivide(input logic [15:0] a, input logic [7:0] b,
                             output logic [15:0] q, output logic [7:0] r,
                             output logic z, output int lat);
    if (b == 8'd0) begin
      q   = 16'hFFFF;
      r   = a[7:0];
      z   = DZ_EN;
      lat = DZ_EN ? 1 : 17;
    end else begin
      q   = a / {8'd0, b};
      r   = 8'(a % {8'd0, b});
      z   = 1'b0;
      lat = 17;
    end
  endtask

  // Wait (bounded) for done; cycles counts edges after the caller's last edge
  task automatic waitDone(output int cycles, output bit found);
    cycles = 0;
    found  = 1'b0;
    while (!found && cycles < 60) begin
      @(posedge clk);
      #1;
      cycles++;
      if (done) found = 1'b1;
    end
  endtask

  // Run one division from idle and check latency, results and pulse width.
  // Must be called #1 after a rising edge.
  task automatic applyStimulus(input logic [15:0] a, input logic [7:0] b,
                               input string tag);
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_z;
    int          exp_lat;
    int          cycles;
    bit          found;
    modelDivide(a, b, exp_q, exp_r, exp_z, exp_lat);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = 16'($urandom_range(0, 16'hFFFF));
    divisor  = 8'($urandom_range(0, 8'hFF));
    waitDone(cycles, found);
    if (!found) begin
      checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    end else begin
      checkOutput({tag, "_latency"}, cycles, exp_lat);
      checkOutput({tag, "_quotient"}, quotient, exp_q);
      checkOutput({tag, "_remainder"}, remainder, exp_r);
      checkOutput({tag, "_dz"}, dz, exp_z);
      checkOutput({tag, "_busy_at_done"}, busy, 1'b0);
      @(posedge clk);
      #1;
      checkOutput({tag, "_done_one_cycle"}, done, 1'b0);
      checkOutput({tag, "_quotient_held"}, quotient, exp_q);
    end
  endtask

  initial begin
    logic [15:0] exp_q;
    logic [7:0]  exp_r;
    logic        exp_z;
    int          exp_lat;
    int          cycles;
    bit          found;
    int          pulses_before;
    int          first_c;
    int          second_c;
    int          npulse;

    total       = 0;
    bad         = 0;
    done_pulses = 0;
    rst         = 1'b1;
    start       = 1'b0;
    dividend    = '0;
    divisor     = '0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("rst_busy", busy, 1'b0);
    checkOutput("rst_done", done, 1'b0);
    checkOutput("rst_dz", dz, 1'b0);
    checkOutput("rst_quotient", quotient, 16'h0000);
    checkOutput("rst_remainder", remainder, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("idle_no_done", done, 1'b0);

    // Directed operand cases
    applyStimulus(16'h03E8, 8'h07, "d1000_7");
    applyStimulus(16'hFFFF, 8'hFF, "dFFFF_FF");
    applyStimulus(16'h0005, 8'h09, "d5_9");
    applyStimulus(16'h1234, 8'h00, "div_zero");
    applyStimulus(16'hFFFF, 8'h01, "dFFFF_1");

    // Busy must rise on the edge that accepts start
    start    = 1'b1;
    dividend = 16'h0100;
    divisor  = 8'h03;
    @(posedge clk);
    #1;
    start = 1'b0;
    checkOutput("busy_after_start", busy, 1'b1);
    waitDone(cycles, found);
    checkOutput("busy_run_found", found, 1'b1);

    // Randomized operands, with an occasional zero divisor
    for (int i = 0; i < 25; i++) begin
      logic [15:0] a;
      logic [7:0]  b;
      a = 16'($urandom_range(0, 16'hFFFF));
      b = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      applyStimulus(a, b, $sformatf("rand%0d", i));
    end

    // A second start during RUN is ignored
    modelDivide(16'h1234, 8'h56, exp_q, exp_r, exp_z, exp_lat);
    pulses_before = done_pulses;
    start    = 1'b1;
    dividend = 16'h1234;
    divisor  = 8'h56;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    start    = 1'b1;
    dividend = 16'hFFFF;
    divisor  = 8'h01;
    @(posedge clk);
    #1;
    start = 1'b0;
    waitDone(cycles, found);
    checkOutput("ignore_found", found, 1'b1);
    checkOutput("ignore_latency", cycles + 5, exp_lat);
    checkOutput("ignore_quotient", quotient, exp_q);
    checkOutput("ignore_remainder", remainder, exp_r);
    repeat (25) @(posedge clk);
    #1;
    checkOutput("ignore_one_pulse", done_pulses - pulses_before, 1);

    // Reset in the middle of RUN aborts the operation
    start    = 1'b1;
    dividend = 16'h03E8;
    divisor  = 8'h07;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    pulses_before = done_pulses;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    checkOutput("abort_busy", busy, 1'b0);
    checkOutput("abort_quotient", quotient, 16'h0000);
    checkOutput("abort_remainder", remainder, 8'h00);
    repeat (20) @(posedge clk);
    #1;
    checkOutput("abort_no_done", done_pulses - pulses_before, 0);

    // start held high: back-to-back operations
    first_c  = -1;
    second_c = -1;
    npulse   = 0;
    start    = 1'b1;
    dividend = 16'h0064;
    divisor  = 8'h0A;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (done) begin
        npulse++;
        if (npulse == 1) first_c = c;
        if (npulse == 2) second_c = c;
        checkOutput($sformatf("b2b_quotient%0d", npulse), quotient, 16'h000A);
        checkOutput($sformatf("b2b_remainder%0d", npulse), remainder, 8'h00);
      end
    end
    start = 1'b0;
    checkOutput("b2b_pulses", npulse, 2);
    checkOutput("b2b_first", first_c, 18);
    checkOutput("b2b_gap", second_c - first_c, 18);
    waitDone(cycles, found);
    checkOutput("b2b_drain", found, 1'b1);
    repeat (3) @(posedge clk);
    #1;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
